reg_file: RTL and testbench

//  General-purpose register file for the CPU datapath: 16 x 32-bit registers,
//  two asynchronous read ports and one synchronous write port. Address 9 is
//  not storage: reads of address 9 return the external r9 input, which carries
//  a datapath-supplied value. Sits between decode (addresses) and the ALU/

---
 rtl/reg_file.sv | 53 +++++
 tb/tb_reg_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 16 x 32-bit register file with two combinational read ports and one clocked write port.
// Reads of EXT_ADDR return the external r9 input instead of the stored slot.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int EXT_ADDR   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] r9,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] EXT_SEL = ADDR_WIDTH'(EXT_ADDR);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // NOTE: start from the current contents so every element has a value on
  // every path; a missing default here would infer latches.
  always_comb begin
    regs_d = regs_q;
    if (writeEnable) begin
      regs_d[writeAddr] = writeData;
    end
  end

  // NOTE: the whole array is cleared by the async reset, so it maps to
  // flops rather than a RAM macro; RAMs cannot be reset in one step.
  // NOTE: non-blocking assignments keep every register updating from
  // pre-edge values, which gives read-old-before-edge semantics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // The EXT_ADDR slot is still written but is shadowed by r9 on both ports.
  assign readData1 = (readAddr1 == EXT_SEL) ? r9 : regs_q[readAddr1];
  assign readData2 = (readAddr2 == EXT_SEL) ? r9 : regs_q[readAddr2];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, writes, r9 override,
// same-cycle read/write ordering and reset-over-write priority.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        writeEnable;
  logic [3:0]  readAddr1;
  logic [3:0]  readAddr2;
  logic [3:0]  writeAddr;
  logic [31:0] writeData;
  logic [31:0] r9;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int checks   = 0;
  int failures = 0;

  reg_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .writeEnable (writeEnable),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .r9          (r9),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step past one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    writeEnable = 1'b1;
    writeAddr   = addr;
    writeData   = data;
    tick();
    writeEnable = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    writeEnable = 1'b0;
    readAddr1   = 4'd0;
    readAddr2   = 4'd1;
    writeAddr   = 4'd0;
    writeData   = 32'h0;
    r9          = 32'h0;
    #12;
    check("reset_rd1_addr0", readData1, 32'h0);
    check("reset_rd2_addr1", readData2, 32'h0);
    rst_n = 1'b1;
    tick();

    // Disabled write leaves storage untouched.
    writeEnable = 1'b0;
    writeAddr   = 4'd2;
    writeData   = 32'hA5A5_A5A5;
    tick();
    readAddr1 = 4'd0;
    readAddr2 = 4'd1;
    #1;
    check("we0_rd1_addr0", readData1, 32'h0);
    check("we0_rd2_addr1", readData2, 32'h0);
    readAddr2 = 4'd2;
    #1;
    check("we0_rd2_addr2", readData2, 32'h0);

    write_reg(4'd2, 32'hA5A5_A5A5);
    check("wr2_rd2_addr2", readData2, 32'hA5A5_A5A5);
    check("wr2_rd1_addr0", readData1, 32'h0);

    // r9 override is combinational on both ports.
    r9        = 32'h1234_5678;
    readAddr1 = 4'd9;
    #1;
    check("r9_rd1_initial", readData1, 32'h1234_5678);
    r9 = 32'hDEAD_BEEF;
    #1;
    check("r9_rd1_follow", readData1, 32'hDEAD_BEEF);
    readAddr2 = 4'd9;
    #1;
    check("r9_rd2", readData2, 32'hDEAD_BEEF);

    write_reg(4'd9, 32'h1111_1111);
    check("wr9_rd1_still_r9", readData1, 32'hDEAD_BEEF);
    r9 = 32'h0;
    #1;
    check("wr9_rd1_r9_zero", readData1, 32'h0);

    write_reg(4'd5, 32'hCAFE_F00D);
    readAddr1 = 4'd5;
    readAddr2 = 4'd5;
    #1;
    check("dual_rd1_addr5", readData1, 32'hCAFE_F00D);
    check("dual_rd2_addr5", readData2, 32'hCAFE_F00D);

    // Same-cycle read and write: old value before the edge, new after.
    writeEnable = 1'b1;
    writeAddr   = 4'd5;
    writeData   = 32'h0;
    #1;
    check("rw_before_edge", readData1, 32'hCAFE_F00D);
    tick();
    writeEnable = 1'b0;
    check("rw_after_edge", readData1, 32'h0);

    // Address 0 and the top address are ordinary storage.
    write_reg(4'd0, 32'h0BAD_C0DE);
    write_reg(4'd15, 32'h8000_0001);
    readAddr1 = 4'd0;
    readAddr2 = 4'd15;
    #1;
    check("wr0_rd1_addr0", readData1, 32'h0BAD_C0DE);
    check("wr15_rd2_addr15", readData2, 32'h8000_0001);
    readAddr1 = 4'd2;
    #1;
    check("addr2_retained", readData1, 32'hA5A5_A5A5);

    // Asynchronous reset between edges clears storage at once.
    write_reg(4'd3, 32'h0000_FFFF);
    readAddr1 = 4'd3;
    readAddr2 = 4'd0;
    #1;
    check("wr3_rd1_addr3", readData1, 32'h0000_FFFF);
    r9    = 32'h5555_AAAA;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr3", readData1, 32'h0);
    check("async_rst_addr0", readData2, 32'h0);
    readAddr2 = 4'd9;
    #1;
    check("async_rst_r9", readData2, 32'h5555_AAAA);

    // Reset held across an edge blocks an enabled write.
    writeEnable = 1'b1;
    writeAddr   = 4'd4;
    writeData   = 32'hFFFF_FFFF;
    readAddr1   = 4'd4;
    tick();
    check("rst_blocks_write", readData1, 32'h0);
    writeEnable = 1'b0;
    rst_n       = 1'b1;
    tick();
    check("post_rst_addr4", readData1, 32'h0);

    write_reg(4'd4, 32'h1357_9BDF);
    check("post_rst_write", readData1, 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
